// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the SDRAM arbiter: FSM states, owner codes
// and the video-RAM shadow bank decode value.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_TAPE = 2'd2;
    localparam logic [1:0] OWN_DMA  = 2'd3;

    localparam logic [8:0] VRAM_BANK_HI = 9'h001;

endpackage

// File: rtl/ram_arb_prio.sv
// Requester pick (DMA > tape > CPU) with a tape burst counter that forces one
// CPU grant after TAPE_BURST back-to-back tape grants while the CPU waits.
module ram_arb_prio
    import ram_arb_pkg::*;
#(
    parameter int TAPE_BURST = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       grant,
    input  logic       dma_req,
    input  logic       tape_req,
    input  logic       cpu_req,
    output logic [1:0] pick
);

    localparam int CW = $clog2(TAPE_BURST + 1);

    logic [CW-1:0] burst_q;
    logic [CW-1:0] burst_d;
    logic          burst_full;

    assign burst_full = (burst_q >= CW'(TAPE_BURST));

    always_comb begin
        pick = OWN_NONE;
        if (dma_req) begin
            pick = OWN_DMA;
        end else if (cpu_req && (burst_full || !tape_req)) begin
            pick = OWN_CPU;
        end else if (tape_req) begin
            pick = OWN_TAPE;
        end
    end

    // Only tape grants made while the CPU is waiting extend the burst.
    always_comb begin
        burst_d = burst_q;
        if (grant) begin
            case (pick)
                OWN_CPU:  burst_d = '0;
                OWN_TAPE: burst_d = cpu_req ? burst_q + CW'(1) : '0;
                default:  burst_d = burst_q;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Three-port SDRAM arbiter (DMA write, tape read, CPU read/write) with one
// transaction in flight. Optional shadow video-RAM strobe: RAM_ARB_VRAM_SHADOW_EN.
//
// state   | meaning
// IDLE    | pick a requester, latch its address/data and owner
// ISSUE   | one-cycle ram_rd / ram_we strobe
// WAIT    | hold address/data until ram_ready, then capture ram_dout
// DONE    | one-cycle ack to the owner, owner returns to none
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int TAPE_BURST = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dma_req,
    input  logic [24:0] dma_addr,
    input  logic [7:0]  dma_din,
    output logic        dma_ack,
    input  logic        tape_req,
    input  logic [24:0] tape_addr,
    output logic [7:0]  tape_dout,
    output logic        tape_ack,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [24:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic        cpu_wait,
    output logic [24:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_rd,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    input  logic        ram_ready,
    output logic        vram_we,
    output logic [1:0]  owner
);

    arb_state_e  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [24:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        we_q, we_d;
    logic [7:0]  tape_dout_q, tape_dout_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;

    logic        cpu_req;
    logic        grant;
    logic [1:0]  pick;
    logic        done;

    assign cpu_req = cpu_rd | cpu_wr;
    assign grant   = (state_q == S_IDLE) && (pick != OWN_NONE);

    ram_arb_prio #(.TAPE_BURST(TAPE_BURST)) u_prio (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .grant    (grant),
        .dma_req  (dma_req),
        .tape_req (tape_req),
        .cpu_req  (cpu_req),
        .pick     (pick)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        din_d       = din_q;
        we_d        = we_q;
        tape_dout_d = tape_dout_q;
        cpu_dout_d  = cpu_dout_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d = S_ISSUE;
                    owner_d = pick;
                    case (pick)
                        OWN_DMA: begin
                            addr_d = dma_addr;
                            din_d  = dma_din;
                            we_d   = 1'b1;
                        end
                        OWN_TAPE: begin
                            addr_d = tape_addr;
                            we_d   = 1'b0;
                        end
                        default: begin
                            addr_d = cpu_addr;
                            din_d  = cpu_din;
                            we_d   = cpu_wr;
                        end
                    endcase
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (ram_ready) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_TAPE) begin
                        tape_dout_d = ram_dout;
                    end else if (owner_q == OWN_CPU && !we_q) begin
                        cpu_dout_d = ram_dout;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            tape_dout_q <= '0;
            cpu_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            tape_dout_q <= tape_dout_d;
            cpu_dout_q  <= cpu_dout_d;
        end
    end

    assign done      = (state_q == S_DONE);
    assign ram_rd    = (state_q == S_ISSUE) && !we_q;
    assign ram_we    = (state_q == S_ISSUE) && we_q;
    assign ram_addr  = addr_q;
    assign ram_din   = din_q;
    assign owner     = owner_q;
    assign dma_ack   = done && (owner_q == OWN_DMA);
    assign tape_ack  = done && (owner_q == OWN_TAPE);
    assign cpu_ack   = done && (owner_q == OWN_CPU);
    assign tape_dout = tape_dout_q;
    assign cpu_dout  = cpu_dout_q;
    assign cpu_wait  = reset_n && cpu_req && !cpu_ack;

`ifdef RAM_ARB_VRAM_SHADOW_EN
    // Banks 5 and 7 are the two video pages mirrored into the shadow RAM.
    assign vram_we = ram_we && (addr_q[24:16] == VRAM_BANK_HI) && addr_q[14];
`else
    assign vram_we = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed grant orders, latencies and data.
module tb_ram_arbiter;

    localparam int TB_BURST = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        dma_req = 1'b0;
    logic [24:0] dma_addr = '0;
    logic [7:0]  dma_din = '0;
    logic        dma_ack;
    logic        tape_req = 1'b0;
    logic [24:0] tape_addr = '0;
    logic [7:0]  tape_dout;
    logic        tape_ack;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [24:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        cpu_wait;
    logic [24:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_rd;
    logic        ram_we;
    logic [7:0]  ram_dout = '0;
    logic        ram_ready = 1'b1;
    logic        vram_we;
    logic [1:0]  owner;

    ram_arbiter #(.TAPE_BURST(TB_BURST)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_din   (dma_din),
        .dma_ack   (dma_ack),
        .tape_req  (tape_req),
        .tape_addr (tape_addr),
        .tape_dout (tape_dout),
        .tape_ack  (tape_ack),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .cpu_wait  (cpu_wait),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_rd    (ram_rd),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .ram_ready (ram_ready),
        .vram_we   (vram_we),
        .owner     (owner)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: one transaction record, timed by cycle numbers.
    int          cyc = 0;
    bit          started = 1'b0;
    bit          busy = 1'b0;
    int          g_cyc = 0;
    int          rdy_cyc = -1;
    logic [1:0]  m_owner = 2'd0;
    logic        m_we = 1'b0;
    logic [24:0] m_addr = '0;
    logic [7:0]  m_din = '0;
    logic [7:0]  m_tdout = '0;
    logic [7:0]  m_cdout = '0;
    int          m_burst = 0;
    logic        m_cr;

    always @(posedge clk_sys) begin
        m_cr = cpu_rd | cpu_wr;
        if (!reset_n) begin
            busy = 1'b0; m_owner = 2'd0; m_we = 1'b0; m_addr = '0; m_din = '0;
            m_tdout = '0; m_cdout = '0; m_burst = 0; rdy_cyc = -1;
        end else if (!busy) begin
            if (dma_req) begin
                busy = 1'b1; m_owner = 2'd3; m_addr = dma_addr; m_din = dma_din; m_we = 1'b1;
            end else if (m_cr && (!tape_req || m_burst >= TB_BURST)) begin
                busy = 1'b1; m_owner = 2'd1; m_addr = cpu_addr; m_din = cpu_din; m_we = cpu_wr;
                m_burst = 0;
            end else if (tape_req) begin
                busy = 1'b1; m_owner = 2'd2; m_addr = tape_addr; m_we = 1'b0;
                m_burst = m_cr ? m_burst + 1 : 0;
            end
            if (busy) begin
                g_cyc = cyc;
                rdy_cyc = -1;
            end
        end else if (rdy_cyc >= 0 && cyc == rdy_cyc + 1) begin
            busy = 1'b0;
        end else if (rdy_cyc < 0 && cyc >= g_cyc + 2 && ram_ready) begin
            rdy_cyc = cyc;
            if (m_owner == 2'd2) m_tdout = ram_dout;
            else if (m_owner == 2'd1 && !m_we) m_cdout = ram_dout;
        end
        started = 1'b1;
        cyc++;
    end

    // Observed strobes (for the directed literal checks) and ack count.
    logic [1:0]  q_own[$];
    logic        q_we[$];
    logic [24:0] q_addr[$];
    logic [7:0]  q_din[$];
    logic        q_vram[$];
    int          n_ack = 0;

    logic       e_strobe, e_ack, e_vram;
    logic [1:0] e_owner;

    always @(negedge clk_sys) begin
        if (started) begin
            e_strobe = busy && (cyc == g_cyc + 1);
            e_ack    = busy && (rdy_cyc >= 0) && (cyc == rdy_cyc + 1);
            e_owner  = busy ? m_owner : 2'd0;
`ifdef RAM_ARB_VRAM_SHADOW_EN
            e_vram = e_strobe && m_we && (m_addr[24:16] == 9'h001) && m_addr[14];
`else
            e_vram = 1'b0;
`endif
            check("owner", owner, e_owner);
            check("ram_rd", ram_rd, e_strobe && !m_we);
            check("ram_we", ram_we, e_strobe && m_we);
            check("ram_addr", ram_addr, m_addr);
            if (busy && m_we) check("ram_din", ram_din, m_din);
            check("dma_ack", dma_ack, e_ack && m_owner == 2'd3);
            check("tape_ack", tape_ack, e_ack && m_owner == 2'd2);
            check("cpu_ack", cpu_ack, e_ack && m_owner == 2'd1);
            check("cpu_wait", cpu_wait,
                  reset_n && (cpu_rd || cpu_wr) && !(e_ack && m_owner == 2'd1));
            check("tape_dout", tape_dout, m_tdout);
            check("cpu_dout", cpu_dout, m_cdout);
            check("vram_we", vram_we, e_vram);
            if (ram_rd || ram_we) begin
                q_own.push_back(owner);
                q_we.push_back(ram_we);
                q_addr.push_back(ram_addr);
                q_din.push_back(ram_din);
                q_vram.push_back(vram_we);
            end
            n_ack += int'(dma_ack) + int'(tape_ack) + int'(cpu_ack);
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_log();
        q_own.delete(); q_we.delete(); q_addr.delete(); q_din.delete(); q_vram.delete();
    endtask

    task automatic wait_ack(input int sel, input int budget, input string nm, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((sel == 1 && cpu_ack) || (sel == 2 && tape_ack) || (sel == 3 && dma_ack)) begin
                at = cyc;
                break;
            end
        end
        check(nm, (at < 0), 1'b0);
    endtask

    logic [1:0] exp_ord [6] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
    logic       exp_vram;

    initial begin
        int at;
        int req_cyc;
        int ack0;

        // Reset
        repeat (3) step();
        check("rst_owner", owner, 2'd0);
        check("rst_ram_addr", ram_addr, 25'h0);
        check("rst_strobes", {ram_rd, ram_we, vram_we}, 3'b000);
        reset_n = 1'b1;
        step();

        // DMA beats a concurrent CPU read
        clear_log();
        ram_ready = 1'b1; ram_dout = 8'h3C;
        dma_req = 1'b1; dma_addr = 25'h0A0000; dma_din = 8'h5A;
        cpu_rd = 1'b1; cpu_addr = 25'h000123;
        wait_ack(3, 10, "dma_ack_timeout", at);
        dma_req = 1'b0;
        wait_ack(1, 10, "cpu_ack_after_dma_timeout", at);
        cpu_rd = 1'b0;
        repeat (3) step();
        check("dma_first_nstrobes", q_own.size(), 2);
        if (q_own.size() >= 2) begin
            check("dma_first_owner", q_own[0], 2'd3);
            check("dma_first_we", q_we[0], 1'b1);
            check("dma_first_addr", q_addr[0], 25'h0A0000);
            check("dma_first_din", q_din[0], 8'h5A);
            check("cpu_second_owner", q_own[1], 2'd1);
            check("cpu_second_rd", q_we[1], 1'b0);
        end

        // Tape burst fairness
        clear_log();
        ram_dout = 8'h11;
        tape_req = 1'b1; tape_addr = 25'h000200;
        cpu_rd = 1'b1; cpu_addr = 25'h000300;
        for (int i = 0; i < 60 && q_own.size() < 6; i++) step();
        tape_req = 1'b0; cpu_rd = 1'b0;
        repeat (6) step();
        check("burst_nstrobes", q_own.size(), 6);
        for (int i = 0; i < 6 && i < q_own.size(); i++) check("burst_order", q_own[i], exp_ord[i]);
        check("burst_tape_dout", tape_dout, 8'h11);

        // CPU read with ram_ready late by 5 cycles
        ram_ready = 1'b0; ram_dout = 8'hC3;
        cpu_rd = 1'b1; cpu_addr = 25'h014000;
        req_cyc = cyc;
        repeat (7) step();
        check("slow_wait_high", cpu_wait, 1'b1);
        ram_ready = 1'b1;
        wait_ack(1, 10, "slow_cpu_ack_timeout", at);
        check("slow_latency", at - req_cyc + 1, 9);
        check("slow_cpu_dout", cpu_dout, 8'hC3);
        check("slow_wait_at_ack", cpu_wait, 1'b0);
        cpu_rd = 1'b0;
        repeat (3) step();

        // Reset during WAIT
        ram_ready = 1'b0;
        cpu_rd = 1'b1; cpu_addr = 25'h000400;
        repeat (2) step();
        ack0 = n_ack;
        reset_n = 1'b0;
        step();
        check("abort_owner", owner, 2'd0);
        check("abort_ram_addr", ram_addr, 25'h0);
        check("abort_cpu_dout", cpu_dout, 8'h00);
        check("abort_tape_dout", tape_dout, 8'h00);
        check("abort_cpu_wait", cpu_wait, 1'b0);
        check("abort_strobes", {ram_rd, ram_we, cpu_ack}, 3'b000);
        repeat (2) step();
        cpu_rd = 1'b0;
        reset_n = 1'b1;
        ram_ready = 1'b1;
        repeat (3) step();
        check("abort_no_ack", n_ack - ack0, 0);

        // CPU write into a shadowed video bank
        clear_log();
        cpu_wr = 1'b1; cpu_addr = 25'h01C000; cpu_din = 8'hA5;
        wait_ack(1, 10, "vram_ack_timeout", at);
        cpu_wr = 1'b0;
        repeat (3) step();
`ifdef RAM_ARB_VRAM_SHADOW_EN
        exp_vram = 1'b1;
`else
        exp_vram = 1'b0;
`endif
        check("vram_nstrobes", q_own.size(), 1);
        if (q_own.size() >= 1) begin
            check("vram_write", q_we[0], 1'b1);
            check("vram_din", q_din[0], 8'hA5);
            check("vram_strobe", q_vram[0], exp_vram);
        end

        // Read and write together is a write
        clear_log();
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 25'h000500; cpu_din = 8'h77;
        wait_ack(1, 10, "rdwr_ack_timeout", at);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        repeat (3) step();
        check("rdwr_nstrobes", q_own.size(), 1);
        if (q_own.size() >= 1) begin
            check("rdwr_is_write", q_we[0], 1'b1);
            check("rdwr_din", q_din[0], 8'h77);
        end

        // Tape request withdrawn before it could be granted
        clear_log();
        dma_req = 1'b1; dma_addr = 25'h000600; dma_din = 8'h01;
        step();
        dma_req = 1'b0; tape_req = 1'b1; tape_addr = 25'h000700;
        step();
        tape_req = 1'b0;
        wait_ack(3, 10, "drop_dma_ack_timeout", at);
        repeat (6) step();
        check("drop_nstrobes", q_own.size(), 1);
        if (q_own.size() >= 1) check("drop_only_dma", q_own[0], 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
